// File: rtl/apb_cot_scheduler_pkg.sv
// Shared types and defaults for the APB cotangent request scheduler.
package apb_cot_pkg;

  localparam int unsigned COT_DW = 32;
  localparam logic [COT_DW-1:0] COT_CTRL_ADDR = 32'h0;
  localparam logic [COT_DW-1:0] COT_OUT_ADDR  = 32'h4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_ACCESS = 3'd2,
    ST_RD_SETUP  = 3'd3,
    ST_RD_ACCESS = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/apb_cot_scheduler_arb.sv
// Round-robin arbiter: combinational grant searched from a registered pointer,
// pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_c,
  output logic [IW-1:0]   gnt_idx_c,
  output logic            gnt_any_c
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // First asserted request at or after ptr_q, wrapping at NREQ.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = IW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_any_c && req_i[pos]) begin
        gnt_any_c  = 1'b1;
        gnt_c[pos] = 1'b1;
        gnt_idx_c  = pos;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && gnt_any_c) begin
      ptr_d = (gnt_idx_c == IW'(NREQ - 1)) ? '0 : gnt_idx_c + IW'(1);
    end
  end

endmodule

// File: rtl/apb_cot_scheduler.sv
// Shares the APB cotangent slave between NREQ requesters: each accepted request
// becomes a write of n to the control register followed by a read of the result.
module apb_cot_scheduler
  import apb_cot_pkg::*;
#(
  parameter int unsigned   NREQ      = 2,
  parameter int unsigned   DW        = COT_DW,
  parameter logic [DW-1:0] CTRL_ADDR = DW'(COT_CTRL_ADDR),
  parameter logic [DW-1:0] OUT_ADDR  = DW'(COT_OUT_ADDR),
  parameter int unsigned   TIMEOUT   = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_n,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_err,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [DW-1:0]    PADDR,
  output logic [DW-1:0]    PWDATA,
  input  logic [DW-1:0]    PRDATA,
  input  logic             PREADY
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DW-1:0]   paddr_q, paddr_d, pwdata_q, pwdata_d, rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic [NREQ-1:0] gidx_oh;
  logic            tmo_hit;
  logic [DW-1:0]   n_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign n_arr[g] = req_n[g*DW +: DW];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (PCLK),
    .rst      (PRESET),
    .req_i    (req_valid),
    .accept_i (accept),
    .gnt_c    (gnt),
    .gnt_idx_c(gnt_idx),
    .gnt_any_c(gnt_any)
  );

  // Grant is only offered while idle and out of reset.
  assign accept    = (state_q == ST_IDLE) && gnt_any && !PRESET;
  assign req_ready = ((state_q == ST_IDLE) && !PRESET) ? gnt : '0;
  assign gidx_oh   = NREQ'(1) << gidx_q;
  assign tmo_hit   = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gidx_d   = gnt_idx;
          pwdata_d = n_arr[gnt_idx];
          pwrite_d = 1'b1;
          paddr_d  = CTRL_ADDR;
          psel_d   = 1'b1;
          state_d  = ST_WR_SETUP;
        end
      end
      ST_WR_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WR_ACCESS;
      end
      ST_WR_ACCESS: begin
        if (PREADY) begin
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
          paddr_d  = OUT_ADDR;
          state_d  = ST_RD_SETUP;
        end else if (tmo_hit) begin
          rsp_valid_d = gidx_oh;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      ST_RD_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_RD_ACCESS;
      end
      ST_RD_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = gidx_oh;
          rsp_data_d  = PRDATA;
          state_d     = ST_RESP;
        end else if (tmo_hit) begin
          rsp_valid_d = gidx_oh;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      gidx_q      <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_apb_cot_scheduler.sv
// Directed bench for apb_cot_scheduler with a small APB slave model:
// output_reg returns n+100, or an entry of cot_tab when mode is set.
module tb_apb_cot_scheduler;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned TMO  = 4;

  logic             PCLK, PRESET;
  logic [NREQ-1:0]  req_valid, req_ready, rsp_valid;
  logic [NREQ*DW-1:0] req_n;
  logic [DW-1:0]    rsp_data, PADDR, PWDATA, PRDATA;
  logic             rsp_err, PSEL, PENABLE, PWRITE, PREADY;

  logic        stuck, setup_hi, mode;
  int          waits;
  int          acc;
  logic [31:0] ctrl_q;
  logic [31:0] cot_tab [8];
  logic [31:0] su_addr, su_data;
  logic        su_wr;
  logic [1:0]  seen;
  int          total, bad, lat;

  apb_cot_scheduler #(
    .NREQ(NREQ), .DW(DW), .CTRL_ADDR(32'h0), .OUT_ADDR(32'h4), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus(input string tag, input logic s, input logic e, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    check({tag, "_psel"}, 32'(PSEL), 32'(s));
    check({tag, "_pen"},  32'(PENABLE), 32'(e));
    check({tag, "_pwr"},  32'(PWRITE), 32'(w));
    check({tag, "_addr"}, PADDR, a);
    check({tag, "_wdat"}, PWDATA, d);
  endtask

  task automatic all_zero(input string tag);
    bus(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check({tag, "_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_rspv"},  32'(rsp_valid), 32'h0);
    check({tag, "_err"},   32'(rsp_err), 32'h0);
    check({tag, "_data"},  rsp_data, 32'h0);
  endtask

  // Issue one request, drop it next cycle, and wait for its response.
  task automatic run_one(input string tag, input int idx, input logic [31:0] n,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int l;
    @(negedge PCLK);
    req_n[idx*32 +: 32] = n;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    @(negedge PCLK);
    req_valid = '0;
    l = 1;
    while (rsp_valid == '0 && l < 40) begin
      @(negedge PCLK);
      l++;
    end
    check({tag, "_vec"},  32'(rsp_valid), 32'(1 << idx));
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"},  32'(rsp_err), 32'(exp_err));
    check({tag, "_lat"},  32'(l), 32'(exp_lat));
  endtask

  // Slave model: ready after `waits` ACCESS cycles unless stuck.
  always_comb begin
    PREADY = (PSEL && !PENABLE && setup_hi) ||
             (PSEL && PENABLE && !stuck && (acc >= waits));
    PRDATA = mode ? cot_tab[ctrl_q[2:0]] : ctrl_q + 32'd100;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q <= '0;
      acc    <= 0;
    end else begin
      if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 32'h0) ctrl_q <= PWDATA;
      acc <= (PSEL && PENABLE && !PREADY) ? acc + 1 : 0;
    end
  end

  // Bus stability during ACCESS relative to the preceding SETUP.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (PSEL && !PENABLE) begin
        su_addr <= PADDR;
        su_data <= PWDATA;
        su_wr   <= PWRITE;
      end
      if (PSEL && PENABLE) begin
        check("acc_addr", PADDR, su_addr);
        check("acc_data", PWDATA, su_data);
        check("acc_pwr", 32'(PWRITE), 32'(su_wr));
      end
      if (PENABLE) check("pen_psel", 32'(PSEL), 32'h1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    PRESET = 1'b1; req_valid = '0; req_n = '0;
    stuck = 1'b0; setup_hi = 1'b0; mode = 1'b0; waits = 0;
    cot_tab[0] = 32'h7FFF_FFFF; cot_tab[1] = 32'h0000_A461;
    cot_tab[2] = 32'hFFFF_8AD3; cot_tab[3] = 32'hFFF8_FB20;
    cot_tab[4] = 32'h0000_D8A1; cot_tab[5] = 32'hFFFF_B6C2;
    cot_tab[6] = 32'h0; cot_tab[7] = 32'h0;

    // Reset state, including req_ready masked while requests are pending.
    @(negedge PCLK);
    req_valid = 2'b11;
    #1 all_zero("rst");
    @(negedge PCLK);
    req_valid = '0;
    PRESET = 1'b0;

    // Single request, cycle by cycle; PREADY high in SETUP must be ignored.
    setup_hi = 1'b1;
    @(negedge PCLK);
    req_n[31:0] = 32'd5;
    req_valid = 2'b01;
    #1 check("s_ready", 32'(req_ready), 32'h1);
    @(negedge PCLK);
    bus("s_wsu", 1'b1, 1'b0, 1'b1, 32'h0, 32'd5);
    check("s_busy_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    @(negedge PCLK); bus("s_wac", 1'b1, 1'b1, 1'b1, 32'h0, 32'd5);
    @(negedge PCLK); bus("s_rsu", 1'b1, 1'b0, 1'b0, 32'h4, 32'd5);
    @(negedge PCLK); bus("s_rac", 1'b1, 1'b1, 1'b0, 32'h4, 32'd5);
    @(negedge PCLK);
    check("s_rspv", 32'(rsp_valid), 32'h1);
    check("s_data", rsp_data, 32'd105);
    check("s_err", 32'(rsp_err), 32'h0);
    check("s_psel", 32'(PSEL), 32'h0);
    @(negedge PCLK);
    check("s_rspv_1cyc", 32'(rsp_valid), 32'h0);

    // Fresh pointer, then both requesters held: grants alternate 0,1,0,1.
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    req_n = {32'd2, 32'd1};
    req_valid = 2'b11;
    #1 check("m_ready0", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        @(negedge PCLK);
        lat++;
      end while (rsp_valid == '0 && lat < 40);
      check($sformatf("m%0d_vec", i), 32'(rsp_valid), 32'(1 << (i % 2)));
      check($sformatf("m%0d_data", i), rsp_data, 32'(101 + (i % 2)));
      check($sformatf("m%0d_lat", i), 32'(lat), (i == 0) ? 32'd5 : 32'd6);
      if (i == 3) req_valid = '0;
    end

    // Three wait cycles in each ACCESS phase.
    waits = 3;
    run_one("wait", 0, 32'd7, 32'd107, 1'b0, 11);
    waits = 0;

    // Stuck slave: abort after TMO ACCESS cycles, then a normal request.
    stuck = 1'b1;
    run_one("tmo", 0, 32'd9, 32'd0, 1'b1, 6);
    check("tmo_psel", 32'(PSEL), 32'h0);
    stuck = 1'b0;
    run_one("tmo_next", 1, 32'd3, 32'd103, 1'b0, 5);

    // Reset asserted in RD_ACCESS.
    @(negedge PCLK);
    req_n[31:0] = 32'd4;
    req_valid = 2'b01;
    @(negedge PCLK);
    req_valid = '0;
    repeat (3) @(negedge PCLK);
    check("r_rac_pen", 32'(PENABLE), 32'h1);
    PRESET = 1'b1;
    #1 all_zero("r_mid");
    @(negedge PCLK);
    PRESET = 1'b0;
    seen = '0;
    repeat (8) begin
      @(negedge PCLK);
      seen = seen | rsp_valid;
    end
    check("r_no_rsp", 32'(seen), 32'h0);
    run_one("r_req1", 1, 32'd6, 32'd106, 1'b0, 5);
    @(negedge PCLK);
    req_n = {32'd8, 32'd7};
    req_valid = 2'b11;
    #1 check("r_prio", 32'(req_ready), 32'h1);
    @(negedge PCLK);
    req_valid = '0;
    lat = 1;
    while (rsp_valid == '0 && lat < 40) begin
      @(negedge PCLK);
      lat++;
    end
    check("r_prio_vec", 32'(rsp_valid), 32'h1);
    check("r_prio_data", rsp_data, 32'd107);

    // Output register contents for n = 0..5 from requester 0.
    mode = 1'b1;
    for (int n = 0; n < 6; n++) begin
      run_one($sformatf("cot%0d", n), 0, 32'(n), cot_tab[n], 1'b0, 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_cot_scheduler.md
Name: apb_cot_scheduler

Overview:
Shares the APB cotangent peripheral between NREQ independent requesters. It acts as the APB requester toward the cotangent slave and arbitrates round-robin among pending requests. For each granted request it writes the argument n to the control register, reads the result back from the output register, and returns the result to the winning requester. It replaces hand-sequenced write/read pairs with a single request/response handshake per operation.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 32, data and address width
CTRL_ADDR, 32'h0, address of control_reg (argument n)
OUT_ADDR, 32'h4, address of output_reg (result)
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (>=1)

Ports:
PCLK  in  1  clock, all state updates on rising edge
PRESET  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request pending
req_n  in  NREQ*DW  per-requester argument n, slice i = [i*DW +: DW]
req_ready  out  NREQ  one-hot accept strobe; request i is taken when req_valid[i] && req_ready[i]
rsp_valid  out  NREQ  one-hot one-cycle response strobe, no backpressure
rsp_data  out  DW  result; valid only while any rsp_valid bit is high
rsp_err  out  1  response is a timeout abort; qualified by rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction (1 = write)
PADDR  out  DW  APB address
PWDATA  out  DW  APB write data
PRDATA  in  DW  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset, asynchronous on PRESET high:
  - Outputs: req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, rsp_data = 0.
  - Internal: state = IDLE; round-robin pointer favours requester 0; timeout counter = 0.
  - Reset mid-transfer abandons the transfer immediately; no response is issued.
- FSM states: IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RESP.
- IDLE:
  - req_ready is combinational: one-hot grant to the first asserted req_valid at or after rr_ptr, wrapping at NREQ.
  - On a grant, latch n and the grant index; rr_ptr <= grant+1 mod NREQ; go to WR_SETUP.
  - If no request is pending, stay in IDLE with req_ready = 0.
- WR_SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR=CTRL_ADDR, PWDATA=n.
- WR_ACCESS: same bus values with PENABLE=1.
  - On PREADY: go to RD_SETUP.
  - Else counter++; if counter reaches TIMEOUT, go to RESP with rsp_err=1.
- RD_SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=0, PADDR=OUT_ADDR. PWDATA holds its last value.
- RD_ACCESS: PENABLE=1.
  - On PREADY: capture PRDATA into rsp_data; go to RESP.
  - Timeout is handled as in WR_ACCESS.
- Timeout counter clears on entry to each ACCESS state. A timeout sets rsp_data=0 and PSEL/PENABLE=0 in the next cycle.
- RESP (1 cycle): rsp_valid[grant]=1, PSEL=0, PENABLE=0; go to IDLE.
- Latency with a zero-wait slave:
  - Accept edge in cycle T; WR_SETUP T+1, WR_ACCESS T+2, RD_SETUP T+3, RD_ACCESS T+4, rsp_valid T+5.
  - Next accept no earlier than T+6.
  - Each slave wait cycle adds 1 to latency.
- Invariants:
  - PSEL/PENABLE never assert together outside the ACCESS states.
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS.
  - req_ready is never asserted outside IDLE.
- Boundary conditions:
  - req_valid dropping during a transfer does not affect it (n is already latched).
  - A requester may re-request in the cycle after its rsp_valid.
  - All requesters asserted continuously: grants rotate 0,1,..,NREQ-1,0.
  - PREADY high in a SETUP state is ignored.
  - rr_ptr wraps at NREQ with no skip or duplicate.

Decomposition:
- Package apb_cot_pkg holds:
  - state enum (IDLE..RESP);
  - CTRL_ADDR / OUT_ADDR defaults;
  - DW.
- Sub-module rr_arbiter (NREQ-wide, combinational grant from a registered pointer, pointer update on accept). Reusable for other shared peripherals.

Test Plan:
- Single request: req_valid=01, n=5; bench slave model returns n+100 → APB write addr 0 data 5 at T+1/T+2, read addr 4 at T+3/T+4, rsp_valid=01 at T+5, rsp_data=105, rsp_err=0.
- Simultaneous requests: req0 n=1 and req1 n=2 held high → grants in order 0,1,0,1; responses 101 then 102; rsp_valid one-hot matches the granted requester.
- Wait states: slave holds PREADY low 3 cycles in both ACCESS phases → rsp_valid at T+11; PADDR/PWDATA/PWRITE stable throughout each ACCESS.
- Timeout: TIMEOUT=4, PREADY stuck low → PSEL drops after 4 ACCESS cycles; rsp_valid with rsp_err=1, rsp_data=0; next request then proceeds normally.
- Reset mid-operation: assert PRESET in RD_ACCESS → all outputs 0 in the same cycle, no rsp_valid; after release, a req1-only request completes and req0 has priority if both are asserted.
- Integration with the cotangent slave: n=0..5 from requester 0 → rsp_data equals the value read from output_reg in each case, matching the existing direct write/read sequence.
